// File: rtl/port_route_arb.sv
// port_route_arb: five-port XY router stage for one mesh tile.
// Each input owns a one-word holding register. The route of a held word
// is derived from its destination every cycle and never stored. A
// round-robin arbiter per output picks one held word, and the chosen
// word is registered onto that output for exactly one cycle.

module port_route_arb #(
   parameter logic [2:0] MY_X = 3'd2,
   parameter logic [2:0] MY_Y = 3'd2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] nin,
   input  logic [9:0] sin,
   input  logic [9:0] ein,
   input  logic [9:0] win,
   input  logic [9:0] lin,
   output logic       nrdy,
   output logic       srdy,
   output logic       erdy,
   output logic       wrdy,
   output logic       lrdy,
   output logic [9:0] nout,
   output logic [9:0] sout,
   output logic [9:0] eout,
   output logic [9:0] wout,
   output logic [9:0] lout,
   output logic [7:0] conf_cnt
);

   // Port indices double as the route codes carried on the outputs.
   localparam logic [2:0] PORT_N = 3'b000;
   localparam logic [2:0] PORT_S = 3'b001;
   localparam logic [2:0] PORT_E = 3'b010;
   localparam logic [2:0] PORT_W = 3'b011;
   localparam logic [2:0] PORT_L = 3'b100;
   localparam int         NPORT  = 5;

   logic [9:0] in_word [NPORT];
   logic [4:0] held;
   logic [5:0] dest    [NPORT];
   logic [2:0] route   [NPORT];
   logic [2:0] ptr     [NPORT];
   logic [4:0] req     [NPORT];
   logic [4:0] grant_any;
   logic [2:0] winner  [NPORT];
   logic [4:0] granted;
   logic [4:0] rdy;
   logic [4:0] accept;
   logic       conflict;
   logic [9:0] out_reg [NPORT];
   logic [7:0] conf_reg;

   // Bits [8:6] of every input word carry nothing this stage uses.
   logic unused_bits;
   assign unused_bits = ^{nin[8:6], sin[8:6], ein[8:6], win[8:6], lin[8:6]};

   assign in_word[0] = nin;
   assign in_word[1] = sin;
   assign in_word[2] = ein;
   assign in_word[3] = win;
   assign in_word[4] = lin;

   assign {lrdy, wrdy, erdy, srdy, nrdy} = rdy;

   assign nout     = out_reg[0];
   assign sout     = out_reg[1];
   assign eout     = out_reg[2];
   assign wout     = out_reg[3];
   assign lout     = out_reg[4];
   assign conf_cnt = conf_reg;

   // Adds an offset to a port index, wrapping around the five ports.
   function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] step);
      logic [3:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      if (sum >= 4'd5) begin
         sum = sum - 4'd5;
      end
      return sum[2:0];
   endfunction

   // XY dimension-order routing: resolve X first, then Y, then deliver locally.
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         route[i] = PORT_L;
         if (dest[i][5:3] > MY_X) begin
            route[i] = PORT_E;
         end else if (dest[i][5:3] < MY_X) begin
            route[i] = PORT_W;
         end else if (dest[i][2:0] > MY_Y) begin
            route[i] = PORT_N;
         end else if (dest[i][2:0] < MY_Y) begin
            route[i] = PORT_S;
         end
      end
   end

   // Request matrix: a held word requests exactly the output its route names.
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         req[o] = '0;
         for (int i = 0; i < NPORT; i++) begin
            req[o][i] = held[i] && (route[i] == 3'(o));
         end
      end
   end

   // Round-robin pick per output, scanning upward from its pointer.
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         grant_any[o] = 1'b0;
         winner[o]    = 3'd0;
         for (int k = 0; k < NPORT; k++) begin
            if (!grant_any[o] && req[o][wrap_add(ptr[o], 3'(k))]) begin
               grant_any[o] = 1'b1;
               winner[o]    = wrap_add(ptr[o], 3'(k));
            end
         end
      end
   end

   // Fold per-output grants back onto inputs; each input asks for one output only.
   always_comb begin
      granted = '0;
      for (int o = 0; o < NPORT; o++) begin
         if (grant_any[o]) begin
            granted[winner[o]] = 1'b1;
         end
      end
   end

   // A cycle is a conflict cycle if any output sees two or more requesters.
   always_comb begin
      conflict = 1'b0;
      for (int o = 0; o < NPORT; o++) begin
         if ((req[o] & (req[o] - 5'd1)) != 5'd0) begin
            conflict = 1'b1;
         end
      end
   end

   // Ready depends on registered state only, so there is no path from any input word.
   always_comb begin
      rdy    = ~held | granted;
      accept = '0;
      for (int i = 0; i < NPORT; i++) begin
         accept[i] = in_word[i][9] & rdy[i];
      end
   end

   // Holding registers: load on accept, drain on grant, reload when both happen.
   always_ff @(posedge clk) begin
      if (rst) begin
         held <= '0;
         for (int i = 0; i < NPORT; i++) begin
            dest[i] <= 6'd0;
         end
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            if (accept[i]) begin
               held[i] <= 1'b1;
               dest[i] <= in_word[i][5:0];
            end else if (granted[i]) begin
               held[i] <= 1'b0;
            end
         end
      end
   end

   // Pointers move just past the winner so the next scan starts with its neighbour.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int o = 0; o < NPORT; o++) begin
            ptr[o] <= 3'd0;
         end
      end else begin
         for (int o = 0; o < NPORT; o++) begin
            if (grant_any[o]) begin
               ptr[o] <= wrap_add(winner[o], 3'd1);
            end
         end
      end
   end

   // Output registers carry a single-cycle pulse for each granted word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int o = 0; o < NPORT; o++) begin
            out_reg[o] <= 10'd0;
         end
      end else begin
         for (int o = 0; o < NPORT; o++) begin
            if (grant_any[o]) begin
               out_reg[o] <= {1'b1, 3'(o), dest[winner[o]]};
            end else begin
               out_reg[o] <= 10'd0;
            end
         end
      end
   end

   // Conflict counter counts cycles, not outputs, and sticks at its maximum.
   always_ff @(posedge clk) begin
      if (rst) begin
         conf_reg <= 8'd0;
      end else if (conflict && (conf_reg != 8'hFF)) begin
         conf_reg <= conf_reg + 8'd1;
      end
   end

endmodule

// File: doc/port_route_arb.md
PORT_ROUTE_ARB -- requirements
Module: port_route_arb

Interface
REQ-001 Parameter MY_X, default 3'd2, X coordinate of this router tile.
REQ-002 Parameter MY_Y, default 3'd2, Y coordinate of this router tile.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 nin, sin, ein, win, lin  input  10 each  port words from the pipeline stage: bit9 valid, [8:6] ignored on input, [5:3] dest X, [2:0] dest Y.
REQ-006 nrdy, srdy, erdy, wrdy, lrdy  output  1 each  per-input ready; a word is accepted only when valid and ready are both high in the same cycle.
REQ-007 nout, sout, eout, wout, lout  output  10 each  routed words to the crossbar: bit9 valid, [8:6] route code, [5:0] unchanged dest field.
REQ-008 conf_cnt  output  8  saturating count of arbitration conflicts.

Function
REQ-009 Port index and route code: N=0/3'b000, S=1/3'b001, E=2/3'b010, W=3/3'b011, L=4/3'b100.
REQ-010 Each input SHALL own one holding register: a valid flag plus a 6-bit dest field.
REQ-011 Route computation is XY-order: destX>MY_X -> E; destX<MY_X -> W; else destY>MY_Y -> N; destY<MY_Y -> S; else L.
REQ-012 Route is computed combinationally from the held dest field; it is never stored.
REQ-013 rdy[i] = ~held[i] | grant[i]; rdy is a function of registered state only, with no combinational path from any *in port.
REQ-014 On an accepting edge, the holding register SHALL load dest=in[5:0] and set held=1.
REQ-015 On a grant with no same-cycle accept, held SHALL clear; on grant plus accept, the register SHALL reload with the new word.
REQ-016 Each output port SHALL have a 3-bit round-robin pointer; requesters are scanned from the pointer upward, mod 5, and the first held input requesting that output wins.
REQ-017 After a grant, that output's pointer SHALL become (winner+1) mod 5; with no grant, the pointer is unchanged.
REQ-018 At most one grant per output and at most one per input per cycle (each input requests exactly one output).
REQ-019 Output registers: on the edge following a grant, out[route] = {1'b1, route code, dest}; outputs with no grant load 10'b0.
REQ-020 Latency: accepted at edge t, uncontended -> visible on output after edge t+1, i.e. 2 cycles from input to output; each cycle of lost arbitration adds one cycle.
REQ-021 Output valid is a one-cycle pulse per flit; there is no output backpressure, and a flit is never dropped or duplicated.
REQ-022 Conflict: any output with at least 2 requesters in a cycle; conf_cnt SHALL increment by 1 per such cycle (not per output), and saturate at 8'hFF.
REQ-023 An input word with valid=0 is never captured, whatever its other bits.
REQ-024 The upstream stage SHALL hold its word stable while rdy is low; the block does not latch unaccepted words.

Reset
REQ-025 While rst=1 at a clock edge: all held flags clear, holding dest fields go to 0, all five pointers go to 0, all *out go to 10'b0, conf_cnt goes to 0.
REQ-026 With held flags clear, all rdy outputs read 1 from the first cycle after reset.
REQ-027 Reset asserted mid-operation SHALL discard held and in-flight flits, with no output pulse on the following cycle.
REQ-028 Input words presented during the rst cycle SHALL NOT be captured.

Verification
REQ-029 Reset: rst=1 for 1 cycle with all inputs valid -> all *out=0, all rdy=1, conf_cnt=0; no output pulse on the next 2 cycles.
REQ-030 Local delivery: MY=(2,2), nin=10'b1_000_010_010 for 1 cycle -> after 2 edges lout=10'b1_100_010_010 for exactly 1 cycle; other outputs stay 0.
REQ-031 XY routing: ein dest (5,1) and win dest (2,0) in the same cycle -> eout=10'b1_010_101_001 and sout=10'b1_001_010_000 in the same cycle; conf_cnt=0.
REQ-032 Conflict: nin and sin both dest (4,2) in the same cycle -> eout carries the N flit first; srdy is low for 1 cycle; the S flit appears on the next cycle; conf_cnt=1; E pointer ends at 2.
REQ-033 Fairness: all 5 inputs stream dest (2,2) continuously for 10 cycles -> lout serves N,S,E,W,L,N,... in strict rotation; conf_cnt increments each conflict cycle.
REQ-034 Mid-operation reset: hold a flit (losing arbitration), assert rst -> no output for that flit; rdy=1 and pointers=0 after reset.
